// File: rtl/ram_arb_pkg.sv
// ---------------------------------------------------------------------------
// ram_arb_pkg
// Shared types and constants for the boot/core RAM port arbiter.
//   arb_state_e : arbiter phase (BOOT -> RELEASE -> RUN)
//   owner_e     : which requester the in-flight RAM response belongs to
//   RAM_LATENCY : RAM read latency in cycles (the arbiter is built for 1)
// ---------------------------------------------------------------------------
package ram_arb_pkg;

    typedef enum logic [1:0] {
        BOOT    = 2'd0,
        RELEASE = 2'd1,
        RUN     = 2'd2
    } arb_state_e;

    typedef enum logic [1:0] {
        OWN_NONE  = 2'd0,
        OWN_LD    = 2'd1,
        OWN_INSTR = 2'd2,
        OWN_DATA  = 2'd3
    } owner_e;

    localparam int unsigned RAM_LATENCY = 32'd1;

endpackage

// File: rtl/ram_arb_rr.sv
// ---------------------------------------------------------------------------
// ram_arb_rr
// Two-way grant logic between the core instruction and data ports.
// Build option: ARB_RR_EN
//   defined   : round-robin; on a tie the port not granted last wins. The
//               pointer starts out favouring data and moves on every grant.
//   undefined : fixed priority, data over instruction (no pointer, no clock).
// Ports:
//   clk_sys_i, rst_sys_ni : clock / async active-low reset (ARB_RR_EN only)
//   en                    : arbitration enabled (arbiter is in RUN)
//   instr_req, data_req   : requests
//   instr_gnt, data_gnt   : combinational grants, at most one high
// ---------------------------------------------------------------------------
module ram_arb_rr (
`ifdef ARB_RR_EN
    input  logic clk_sys_i,
    input  logic rst_sys_ni,
`endif
    input  logic en,
    input  logic instr_req,
    input  logic data_req,
    output logic instr_gnt,
    output logic data_gnt
);

`ifdef ARB_RR_EN
    logic prefer_data_r;

    // Grant selection: a lone requester wins, a tie goes to the preferred port.
    always_comb begin
        instr_gnt = 1'b0;
        data_gnt  = 1'b0;
        if (en) begin
            if (instr_req && data_req) begin
                data_gnt  = prefer_data_r;
                instr_gnt = ~prefer_data_r;
            end else begin
                data_gnt  = data_req;
                instr_gnt = instr_req;
            end
        end else begin
            data_gnt  = 1'b0;
            instr_gnt = 1'b0;
        end
    end

    // Pointer: after granting one port, prefer the other.
    always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
        if (!rst_sys_ni) begin
            prefer_data_r <= 1'b1;
        end else if (data_gnt) begin
            prefer_data_r <= 1'b0;
        end else if (instr_gnt) begin
            prefer_data_r <= 1'b1;
        end else begin
            prefer_data_r <= prefer_data_r;
        end
    end
`else
    // Fixed priority: data always beats instruction fetch.
    always_comb begin
        data_gnt  = 1'b0;
        instr_gnt = 1'b0;
        if (en) begin
            data_gnt  = data_req;
            instr_gnt = instr_req & ~data_req;
        end else begin
            data_gnt  = 1'b0;
            instr_gnt = 1'b0;
        end
    end
`endif

endmodule

// File: rtl/ram_boot_arbiter.sv
// ---------------------------------------------------------------------------
// ram_boot_arbiter
// Owns the single RAM port shared by the UART boot loader and the Ibex core.
// BOOT: only the loader is granted, core held in reset. After ld_done_i (taken
// once the loader has no request in the cycle), RELEASE holds the core in
// reset for RST_HOLD cycles, then RUN arbitrates between core instr and data
// ports via ram_arb_rr. Every grant is answered with rvalid one cycle later,
// to the owner recorded at grant time.
// Build option: ARB_RR_EN selects round-robin instead of data>instr priority.
// Ports:
//   clk_sys_i / rst_sys_ni          : clock, async active-low reset
//   ld_*                            : loader request/grant/response, ld_done_i
//   instr_*                         : core fetch port (read only)
//   data_*                          : core LSU port
//   ram_*                           : RAM port, 1-cycle read latency
//   core_rst_no                     : core reset, active low
// ---------------------------------------------------------------------------
module ram_boot_arbiter
    import ram_arb_pkg::*;
#(
    parameter int unsigned AW       = 32,
    parameter int unsigned DW       = 32,
    parameter int unsigned RST_HOLD = 8
) (
    input  logic          clk_sys_i,
    input  logic          rst_sys_ni,
    input  logic          ld_req_i,
    input  logic          ld_we_i,
    input  logic [3:0]    ld_be_i,
    input  logic [AW-1:0] ld_addr_i,
    input  logic [DW-1:0] ld_wdata_i,
    input  logic          ld_done_i,
    output logic          ld_gnt_o,
    output logic          ld_rvalid_o,
    input  logic          instr_req_i,
    input  logic [AW-1:0] instr_addr_i,
    output logic          instr_gnt_o,
    output logic          instr_rvalid_o,
    output logic [DW-1:0] instr_rdata_o,
    input  logic          data_req_i,
    input  logic          data_we_i,
    input  logic [3:0]    data_be_i,
    input  logic [AW-1:0] data_addr_i,
    input  logic [DW-1:0] data_wdata_i,
    output logic          data_gnt_o,
    output logic          data_rvalid_o,
    output logic [DW-1:0] data_rdata_o,
    output logic          ram_req_o,
    output logic          ram_we_o,
    output logic [3:0]    ram_be_o,
    output logic [AW-1:0] ram_addr_o,
    output logic [DW-1:0] ram_wdata_o,
    input  logic [DW-1:0] ram_rdata_i,
    output logic          core_rst_no
);

    localparam int unsigned CW = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
    localparam logic [CW-1:0] HOLD_LAST = CW'(RST_HOLD - 1);

    arb_state_e    state_r, state_s;
    logic [CW-1:0] hold_cnt_r, hold_cnt_s;
    logic          done_sticky_r, done_sticky_s;
    owner_e        owner_r, owner_s;
    logic          core_rst_r;
    logic          ld_gnt_s, instr_gnt_s, data_gnt_s;

    assign ld_gnt_s = (state_r == BOOT) & ld_req_i;

    ram_arb_rr u_rr (
`ifdef ARB_RR_EN
        .clk_sys_i  (clk_sys_i),
        .rst_sys_ni (rst_sys_ni),
`endif
        .en         (state_r == RUN),
        .instr_req  (instr_req_i),
        .data_req   (data_req_i),
        .instr_gnt  (instr_gnt_s),
        .data_gnt   (data_gnt_s)
    );

    assign ld_gnt_o       = ld_gnt_s;
    assign instr_gnt_o    = instr_gnt_s;
    assign data_gnt_o     = data_gnt_s;
    assign ram_req_o      = ld_gnt_s | instr_gnt_s | data_gnt_s;
    assign ld_rvalid_o    = (owner_r == OWN_LD);
    assign instr_rvalid_o = (owner_r == OWN_INSTR);
    assign data_rvalid_o  = (owner_r == OWN_DATA);
    assign instr_rdata_o  = ram_rdata_i;
    assign data_rdata_o   = ram_rdata_i;
    assign core_rst_no    = core_rst_r;

    // RAM control mux and owner of the response due next cycle.
    always_comb begin
        ram_we_o    = 1'b0;
        ram_be_o    = 4'h0;
        ram_addr_o  = {AW{1'b0}};
        ram_wdata_o = {DW{1'b0}};
        owner_s     = OWN_NONE;
        if (ld_gnt_s) begin
            ram_we_o    = ld_we_i;
            ram_be_o    = ld_be_i;
            ram_addr_o  = ld_addr_i;
            ram_wdata_o = ld_wdata_i;
            owner_s     = OWN_LD;
        end else if (data_gnt_s) begin
            ram_we_o    = data_we_i;
            ram_be_o    = data_be_i;
            ram_addr_o  = data_addr_i;
            ram_wdata_o = data_wdata_i;
            owner_s     = OWN_DATA;
        end else if (instr_gnt_s) begin
            ram_we_o    = 1'b0;
            ram_be_o    = 4'hF;
            ram_addr_o  = instr_addr_i;
            owner_s     = OWN_INSTR;
        end else begin
            owner_s     = OWN_NONE;
        end
    end

    // Phase sequencing. A done seen while the loader is still requesting is
    // kept in the sticky flag; a response being returned this cycle completes
    // this cycle, so it does not hold back the move to RELEASE.
    always_comb begin
        state_s       = state_r;
        hold_cnt_s    = hold_cnt_r;
        done_sticky_s = done_sticky_r;
        case (state_r)
            BOOT: begin
                if ((ld_done_i || done_sticky_r) && !ld_req_i) begin
                    state_s       = RELEASE;
                    hold_cnt_s    = {CW{1'b0}};
                    done_sticky_s = 1'b0;
                end else if (ld_done_i) begin
                    done_sticky_s = 1'b1;
                end else begin
                    done_sticky_s = done_sticky_r;
                end
            end
            RELEASE: begin
                if (hold_cnt_r == HOLD_LAST) begin
                    state_s    = RUN;
                    hold_cnt_s = {CW{1'b0}};
                end else begin
                    hold_cnt_s = hold_cnt_r + {{(CW-1){1'b0}}, 1'b1};
                end
            end
            RUN: begin
                state_s = RUN;
            end
            default: begin
                state_s       = BOOT;
                hold_cnt_s    = {CW{1'b0}};
                done_sticky_s = 1'b0;
            end
        endcase
    end

    // State, counters, owner and registered core reset.
    always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
        if (!rst_sys_ni) begin
            state_r       <= BOOT;
            hold_cnt_r    <= {CW{1'b0}};
            done_sticky_r <= 1'b0;
            owner_r       <= OWN_NONE;
            core_rst_r    <= 1'b0;
        end else begin
            state_r       <= state_s;
            hold_cnt_r    <= hold_cnt_s;
            done_sticky_r <= done_sticky_s;
            owner_r       <= owner_s;
            core_rst_r    <= (state_s == RUN);
        end
    end

endmodule

// File: tb/tb_ram_boot_arbiter.sv
module tb_ram_boot_arbiter;

    localparam int unsigned RST_HOLD = 8;
    localparam logic [1:0] P_LD = 2'd1;
    localparam logic [1:0] P_IN = 2'd2;
    localparam logic [1:0] P_DA = 2'd3;

    logic        clk, rst_n;
    logic        ld_req, ld_we, ld_done, ld_gnt, ld_rvalid;
    logic [3:0]  ld_be;
    logic [31:0] ld_addr, ld_wdata;
    logic        instr_req, instr_gnt, instr_rvalid;
    logic [31:0] instr_addr, instr_rdata;
    logic        data_req, data_we, data_gnt, data_rvalid;
    logic [3:0]  data_be;
    logic [31:0] data_addr, data_wdata, data_rdata;
    logic        ram_req, ram_we, core_rst_n;
    logic [3:0]  ram_be;
    logic [31:0] ram_addr, ram_wdata, ram_rdata;

    typedef struct {
        logic [1:0]  port;
        logic        chk_data;
        logic [31:0] data;
    } exp_t;

    exp_t q[$];
    int n_chk = 0;
    int n_err = 0;
    logic [31:0] mem [0:63];

    ram_boot_arbiter #(.AW(32), .DW(32), .RST_HOLD(RST_HOLD)) dut (
        .clk_sys_i(clk), .rst_sys_ni(rst_n),
        .ld_req_i(ld_req), .ld_we_i(ld_we), .ld_be_i(ld_be), .ld_addr_i(ld_addr),
        .ld_wdata_i(ld_wdata), .ld_done_i(ld_done), .ld_gnt_o(ld_gnt),
        .ld_rvalid_o(ld_rvalid),
        .instr_req_i(instr_req), .instr_addr_i(instr_addr), .instr_gnt_o(instr_gnt),
        .instr_rvalid_o(instr_rvalid), .instr_rdata_o(instr_rdata),
        .data_req_i(data_req), .data_we_i(data_we), .data_be_i(data_be),
        .data_addr_i(data_addr), .data_wdata_i(data_wdata), .data_gnt_o(data_gnt),
        .data_rvalid_o(data_rvalid), .data_rdata_o(data_rdata),
        .ram_req_o(ram_req), .ram_we_o(ram_we), .ram_be_o(ram_be),
        .ram_addr_o(ram_addr), .ram_wdata_o(ram_wdata), .ram_rdata_i(ram_rdata),
        .core_rst_no(core_rst_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] wd, logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
        end
        return r;
    endfunction

    // RAM model: 64 words indexed by addr[7:2], 1-cycle read latency.
    always @(posedge clk) begin
        if (ram_req) begin
            if (ram_we) mem[ram_addr[7:2]] <= merge(mem[ram_addr[7:2]], ram_wdata, ram_be);
            ram_rdata <= mem[ram_addr[7:2]];
        end
    end

    task automatic chk1(string name, logic act, logic exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk32(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(logic [1:0] p, logic cd, logic [31:0] d);
        q.push_back('{port: p, chk_data: cd, data: d});
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ld_req = 1'b0; ld_we = 1'b0; ld_be = 4'h0; ld_addr = 32'h0; ld_wdata = 32'h0;
        ld_done = 1'b0;
        instr_req = 1'b0; instr_addr = 32'h0;
        data_req = 1'b0; data_we = 1'b0; data_be = 4'h0; data_addr = 32'h0;
        data_wdata = 32'h0;
    endtask

    // Monitor: every rvalid pops one expected response.
    always @(negedge clk) begin : monitor
        logic [2:0]  vv;
        logic [1:0]  port;
        logic [31:0] rd;
        exp_t        e;
        vv = {ld_rvalid, instr_rvalid, data_rvalid};
        if (vv != 3'b000) begin
            if ($countones(vv) > 1) begin
                n_chk++;
                n_err++;
                $display("FAIL rvalid_onehot: got %b expected one-hot at %0t", vv, $time);
            end
            port = ld_rvalid ? P_LD : (instr_rvalid ? P_IN : P_DA);
            rd = ld_rvalid ? ram_rdata : (instr_rvalid ? instr_rdata : data_rdata);
            if (q.size() == 0) begin
                n_chk++;
                n_err++;
                $display("FAIL unexpected_rvalid: got port %0d expected none at %0t", port, $time);
            end else begin
                e = q.pop_front();
                chk32("rsp_port", {30'd0, port}, {30'd0, e.port});
                if (e.chk_data) chk32("rsp_data", rd, e.data);
            end
        end
    end

    initial begin
        logic exp_d;
        rst_n = 1'b0;
        ram_rdata = 32'h0;
        idle_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk1("reset_core_rst", core_rst_n, 1'b0);
        chk32("reset_rvalid", {29'd0, ld_rvalid, instr_rvalid, data_rvalid}, 32'd0);
        next_cycle();
        rst_n = 1'b1;

        // Boot write 1, with instr request competing
        ld_req = 1'b1; ld_we = 1'b1; ld_be = 4'hF;
        ld_addr = 32'h0010_0000; ld_wdata = 32'hDEAD_BEEF;
        instr_req = 1'b1; instr_addr = 32'h0010_0004;
        @(negedge clk);
        chk1("boot_ld_gnt", ld_gnt, 1'b1);
        chk1("boot_instr_gnt", instr_gnt, 1'b0);
        chk1("boot_ram_req", ram_req, 1'b1);
        chk1("boot_ram_we", ram_we, 1'b1);
        chk32("boot_ram_be", {28'd0, ram_be}, 32'hF);
        chk32("boot_ram_addr", ram_addr, 32'h0010_0000);
        chk32("boot_ram_wdata", ram_wdata, 32'hDEAD_BEEF);
        chk1("boot_core_rst", core_rst_n, 1'b0);
        push(P_LD, 1'b0, 32'h0);
        next_cycle();

        // Boot write 2
        ld_addr = 32'h0010_0004; ld_wdata = 32'h1234_5678;
        @(negedge clk);
        chk1("boot2_ld_gnt", ld_gnt, 1'b1);
        chk1("boot2_instr_gnt", instr_gnt, 1'b0);
        chk32("boot2_ram_addr", ram_addr, 32'h0010_0004);
        chk32("boot2_ram_wdata", ram_wdata, 32'h1234_5678);
        push(P_LD, 1'b0, 32'h0);
        next_cycle();

        // Loader read-back with ld_done: done must be deferred by the grant
        ld_we = 1'b0; ld_addr = 32'h0010_0000; ld_done = 1'b1;
        @(negedge clk);
        chk1("done_ld_gnt", ld_gnt, 1'b1);
        chk1("done_ram_we", ram_we, 1'b0);
        push(P_LD, 1'b1, 32'hDEAD_BEEF);
        next_cycle();

        // Response cycle: loader idle; RELEASE starts next cycle
        ld_req = 1'b0; ld_done = 1'b0;
        @(negedge clk);
        chk1("resp_core_rst", core_rst_n, 1'b0);
        chk1("resp_ram_req", ram_req, 1'b0);
        next_cycle();
        for (int k = 1; k <= RST_HOLD; k++) begin
            @(negedge clk);
            chk1("hold_core_rst", core_rst_n, 1'b0);
            chk1("hold_instr_gnt", instr_gnt, 1'b0);
            next_cycle();
        end

        // First RUN cycle: data write alone
        instr_req = 1'b0;
        data_req = 1'b1; data_we = 1'b1; data_be = 4'hF;
        data_addr = 32'h0000_0010; data_wdata = 32'hA5A5_A5A5;
        @(negedge clk);
        chk1("run_core_rst", core_rst_n, 1'b1);
        chk1("run_data_gnt", data_gnt, 1'b1);
        chk1("run_ram_we", ram_we, 1'b1);
        chk32("run_ram_addr", ram_addr, 32'h0000_0010);
        push(P_DA, 1'b0, 32'h0);
        next_cycle();

        // Instr fetch alone: we=0, be=F
        data_req = 1'b0;
        instr_req = 1'b1; instr_addr = 32'h0010_0004;
        @(negedge clk);
        chk1("fetch_instr_gnt", instr_gnt, 1'b1);
        chk1("fetch_ram_we", ram_we, 1'b0);
        chk32("fetch_ram_be", {28'd0, ram_be}, 32'hF);
        push(P_IN, 1'b1, 32'h1234_5678);
        next_cycle();

        // Contention for 3 cycles
        instr_addr = 32'h0010_0000;
        data_req = 1'b1; data_we = 1'b0; data_addr = 32'h0000_0010;
        for (int i = 0; i < 3; i++) begin
`ifdef ARB_RR_EN
            exp_d = (i != 1);
`else
            exp_d = 1'b1;
`endif
            @(negedge clk);
            chk1("cont_data_gnt", data_gnt, exp_d);
            chk1("cont_instr_gnt", instr_gnt, ~exp_d);
            if (exp_d) push(P_DA, 1'b1, 32'hA5A5_A5A5);
            else push(P_IN, 1'b1, 32'hDEAD_BEEF);
            next_cycle();
        end

        // Loader ignored in RUN; idle RAM controls are 0
        idle_inputs();
        ld_req = 1'b1; ld_we = 1'b1; ld_be = 4'hF; ld_addr = 32'h0000_0010;
        ld_wdata = 32'h0; ld_done = 1'b1;
        @(negedge clk);
        chk1("ign_ld_gnt", ld_gnt, 1'b0);
        chk1("ign_ram_req", ram_req, 1'b0);
        chk32("ign_ram_addr", ram_addr, 32'h0);
        chk1("ign_core_rst", core_rst_n, 1'b1);
        next_cycle();

        // Read back: the ignored loader write must not have landed
        idle_inputs();
        data_req = 1'b1; data_addr = 32'h0000_0010;
        @(negedge clk);
        chk1("rb_data_gnt", data_gnt, 1'b1);
        push(P_DA, 1'b1, 32'hA5A5_A5A5);
        next_cycle();

        // Mid-operation reset with a read pending
        data_addr = 32'h0010_0004;
        @(negedge clk);
        chk1("mid_data_gnt", data_gnt, 1'b1);
        next_cycle();
        rst_n = 1'b0;
        data_req = 1'b0;
        @(negedge clk);
        chk1("mid_core_rst", core_rst_n, 1'b0);
        chk32("mid_rvalid", {29'd0, ld_rvalid, instr_rvalid, data_rvalid}, 32'd0);
        next_cycle();
        rst_n = 1'b1;

        // Back in BOOT: loader granted, core still blocked
        ld_req = 1'b1; ld_we = 1'b0; ld_addr = 32'h0010_0004;
        instr_req = 1'b1;
        @(negedge clk);
        chk1("post_ld_gnt", ld_gnt, 1'b1);
        chk1("post_instr_gnt", instr_gnt, 1'b0);
        chk1("post_core_rst", core_rst_n, 1'b0);
        push(P_LD, 1'b1, 32'h1234_5678);
        next_cycle();

        idle_inputs();
        repeat (3) next_cycle();
        chk32("queue_drained", q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
